cr_tlvp_mdsm: RTL and testbench

CR_TLVP_MDSM -- requirements
Module: cr_tlvp_mdsm

---
 rtl/cr_tlvp_mdsm.sv | 218 +++++++++++++++++++++
 tb/tb_cr_tlvp_mdsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_tlvp_mdsm.sv
// TLV demultiplexer: routes framed TLV words by type into a pass-through FIFO
// and/or one of N_USR user FIFOs, with framing-error recovery and counters.

module cr_tlvp_mdsm_fifo #(
  parameter int DEPTH      = 16,
  parameter int E_W        = 67,
  parameter int AEMPTY_VAL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [E_W-1:0] din,
  output logic [E_W-1:0] dout,
  output logic           empty,
  output logic           aempty,
  output logic           full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [E_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign aempty  = (cnt <= CNT_W'(AEMPTY_VAL));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  // Head is gated so an empty FIFO (including under reset) presents zero.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module cr_tlvp_mdsm #(
  parameter  int N_USR      = 2,
  parameter  int DATA_W     = 64,
  parameter  int TYPE_W     = 5,
  parameter  int DEPTH      = 16,
  parameter  int AFULL_VAL  = 3,
  parameter  int AEMPTY_VAL = 1,
  localparam int CH_W       = (N_USR > 1) ? $clog2(N_USR) : 1,
  localparam int A_W        = 2 + CH_W,
  localparam int E_W        = DATA_W + 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic                         in_sot,
  input  logic                         in_eot,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [(2**TYPE_W)*A_W-1:0]   route_tbl,
  input  logic                         pt_rd,
  output logic [E_W-1:0]               pt_data,
  output logic                         pt_empty,
  output logic                         pt_aempty,
  input  logic [N_USR-1:0]             usr_rd,
  output logic [N_USR*E_W-1:0]         usr_data,
  output logic [N_USR-1:0]             usr_empty,
  output logic [N_USR-1:0]             usr_aempty,
  input  logic                         err_clr,
  output logic                         tlvp_error,
  output logic [15:0]                  err_cnt,
  output logic [15:0]                  drop_cnt
);
  if (N_USR < 1 || N_USR > 8 || AFULL_VAL > DEPTH || AEMPTY_VAL >= DEPTH) begin : g_bad_cfg
    $error("cr_tlvp_mdsm: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, BODY, DRAIN} state_t;

  state_t             state, nstate;
  logic               rdy_en;
  logic               cur_pt;
  logic [N_USR-1:0]   cur_usr;

  logic [TYPE_W-1:0]  typ;
  logic [A_W-1:0]     act;
  logic [1:0]         mode;
  logic [CH_W-1:0]    ch;
  logic               ch_ok, bad_route, dec_pt;
  logic [N_USR-1:0]   dec_usr;

  logic               sel_pt, acc, latch, err_ev, drop_ev, wr_err, wr_eot;
  logic [N_USR-1:0]   sel_usr;
  logic               pt_push, pt_full;
  logic [N_USR-1:0]   usr_push, usr_full;
  logic [E_W-1:0]     entry;

  // mode[0] selects the pass-through path, mode[1] selects a user channel.
  assign typ       = in_data[TYPE_W-1:0];
  assign act       = route_tbl[typ*A_W +: A_W];
  assign mode      = act[A_W-1 -: 2];
  assign ch        = act[CH_W-1:0];
  assign ch_ok     = (32'(ch) < N_USR);
  assign bad_route = mode[1] && !ch_ok;
  assign dec_pt    = mode[0];

  always_comb begin
    dec_usr = '0;
    for (int unsigned k = 0; k < N_USR; k++)
      dec_usr[k] = mode[1] && ch_ok && (32'(ch) == k);
  end

  always_comb begin
    nstate  = state;
    sel_pt  = 1'b0;
    sel_usr = '0;
    wr_err  = 1'b0;
    wr_eot  = in_eot;
    latch   = 1'b0;
    err_ev  = 1'b0;
    drop_ev = 1'b0;
    case (state)
      IDLE: if (in_sot) begin
        sel_pt  = dec_pt;
        sel_usr = dec_usr;
      end
      BODY: begin
        sel_pt  = cur_pt;
        sel_usr = cur_usr;
      end
      default: ;
    endcase
    in_rdy = rdy_en && !(sel_pt && pt_full) && !(|(sel_usr & usr_full));
    acc    = in_vld && in_rdy;
    if (acc) begin
      case (state)
        IDLE: if (in_sot) begin
          latch   = 1'b1;
          err_ev  = bad_route;
          drop_ev = (mode == 2'd0);
          nstate  = in_eot ? IDLE : BODY;
        end else begin
          err_ev = 1'b1;
          nstate = in_eot ? IDLE : DRAIN;
        end
        BODY: if (in_sot) begin
          // A nested SOT terminates the open TLV in the FIFOs as an errored frame.
          wr_eot = 1'b1;
          wr_err = 1'b1;
          err_ev = 1'b1;
          nstate = in_eot ? IDLE : DRAIN;
        end else if (in_eot) begin
          nstate = IDLE;
        end
        DRAIN: if (in_eot) nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  assign pt_push  = acc && sel_pt;
  assign usr_push = acc ? sel_usr : '0;
  assign entry    = {wr_err, in_sot, wr_eot, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rdy_en     <= 1'b0;
      cur_pt     <= 1'b0;
      cur_usr    <= '0;
      tlvp_error <= 1'b0;
      err_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state  <= nstate;
      rdy_en <= 1'b1;
      if (latch) begin
        cur_pt  <= dec_pt;
        cur_usr <= dec_usr;
      end
      if (err_ev) begin
        tlvp_error <= 1'b1;
        err_cnt    <= err_clr ? 16'd1 : ((err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1);
      end else if (err_clr) begin
        tlvp_error <= 1'b0;
        err_cnt    <= '0;
      end
      if (drop_ev && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  cr_tlvp_mdsm_fifo #(.DEPTH(DEPTH), .E_W(E_W), .AEMPTY_VAL(AEMPTY_VAL)) u_pt_fifo (
    .clk(clk), .rst(rst), .push(pt_push), .pop(pt_rd), .din(entry),
    .dout(pt_data), .empty(pt_empty), .aempty(pt_aempty), .full(pt_full)
  );

  for (genvar g = 0; g < N_USR; g++) begin : g_usr
    cr_tlvp_mdsm_fifo #(.DEPTH(DEPTH), .E_W(E_W), .AEMPTY_VAL(AEMPTY_VAL)) u_usr_fifo (
      .clk(clk), .rst(rst), .push(usr_push[g]), .pop(usr_rd[g]), .din(entry),
      .dout(usr_data[g*E_W +: E_W]), .empty(usr_empty[g]), .aempty(usr_aempty[g]),
      .full(usr_full[g])
    );
  end
endmodule

// File: tb/tb_cr_tlvp_mdsm.sv
// Bench for cr_tlvp_mdsm: queue-based behavioural model checked every cycle,
// plus directed TLV scenarios with literal expectations.

module tb_cr_tlvp_mdsm;
  localparam int N_USR = 2, DATA_W = 64, TYPE_W = 5, DEPTH = 16;
  localparam int A_W = 3, E_W = DATA_W + 3;

  logic                 clk = 1'b0, rst = 1'b0;
  logic                 in_vld = 1'b0, in_sot = 1'b0, in_eot = 1'b0;
  logic [DATA_W-1:0]    in_data = '0;
  logic [32*A_W-1:0]    route_tbl = '0;
  logic                 pt_rd = 1'b0, err_clr = 1'b0;
  logic [N_USR-1:0]     usr_rd = '0;
  logic                 in_rdy, pt_empty, pt_aempty, tlvp_error;
  logic [E_W-1:0]       pt_data;
  logic [N_USR*E_W-1:0] usr_data;
  logic [N_USR-1:0]     usr_empty, usr_aempty;
  logic [15:0]          err_cnt, drop_cnt;

  cr_tlvp_mdsm #(.N_USR(N_USR), .DATA_W(DATA_W), .TYPE_W(TYPE_W), .DEPTH(DEPTH),
                 .AFULL_VAL(3), .AEMPTY_VAL(1)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_sot(in_sot),
    .in_eot(in_eot), .in_data(in_data), .route_tbl(route_tbl), .pt_rd(pt_rd),
    .pt_data(pt_data), .pt_empty(pt_empty), .pt_aempty(pt_aempty), .usr_rd(usr_rd),
    .usr_data(usr_data), .usr_empty(usr_empty), .usr_aempty(usr_aempty),
    .err_clr(err_clr), .tlvp_error(tlvp_error), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic check(string n, logic [127:0] a, logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q[0] is the pass-through queue, q[k+1] is user channel k.
  logic [E_W-1:0] q [N_USR+1][$];
  bit m_en = 0, m_in = 0, m_drain = 0, m_pt = 0, m_err = 0;
  int m_usr = -1, m_ecnt = 0, m_dcnt = 0;

  function automatic void decode(input logic [DATA_W-1:0] d, output int mode, output int ch);
    logic [A_W-1:0] e;
    e = route_tbl[d[TYPE_W-1:0]*A_W +: A_W];
    mode = int'(e[2:1]);
    ch = int'(e[0]);
  endfunction

  function automatic bit m_ready();
    int mode, ch, u;
    bit p;
    if (!m_en) return 1'b0;
    if (m_drain) return 1'b1;
    if (!m_in) begin
      if (!in_sot) return 1'b1;
      decode(in_data, mode, ch);
      p = (mode % 2) == 1;
      u = (mode >= 2 && ch < N_USR) ? ch : -1;
    end else begin
      p = m_pt;
      u = m_usr;
    end
    if (p && q[0].size() == DEPTH) return 1'b0;
    if (u >= 0 && q[u+1].size() == DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void mpush(bit p, int u, logic [E_W-1:0] e);
    if (p) q[0].push_back(e);
    if (u >= 0) q[u+1].push_back(e);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit acc, ev;
    int mode, ch;
    logic [E_W-1:0] e;
    if (rst) begin
      for (int i = 0; i <= N_USR; i++) q[i].delete();
      m_en = 0; m_in = 0; m_drain = 0; m_pt = 0; m_usr = -1;
      m_err = 0; m_ecnt = 0; m_dcnt = 0;
    end else begin
      acc = in_vld && m_ready();
      ev = 0;
      if (pt_rd && q[0].size() > 0) void'(q[0].pop_front());
      for (int k = 0; k < N_USR; k++)
        if (usr_rd[k] && q[k+1].size() > 0) void'(q[k+1].pop_front());
      if (acc) begin
        e = {1'b0, in_sot, in_eot, in_data};
        if (m_drain) begin
          if (in_eot) m_drain = 0;
        end else if (!m_in) begin
          if (in_sot) begin
            decode(in_data, mode, ch);
            m_pt = (mode % 2) == 1;
            m_usr = (mode >= 2 && ch < N_USR) ? ch : -1;
            if (mode >= 2 && ch >= N_USR) begin m_pt = 0; ev = 1; end
            if (mode == 0 && m_dcnt < 65535) m_dcnt++;
            mpush(m_pt, m_usr, e);
            m_in = !in_eot;
          end else begin
            ev = 1;
            m_drain = !in_eot;
          end
        end else begin
          if (in_sot) begin
            mpush(m_pt, m_usr, {1'b1, 1'b1, 1'b1, in_data});
            ev = 1;
            m_in = 0;
            m_drain = !in_eot;
          end else begin
            mpush(m_pt, m_usr, e);
            if (in_eot) m_in = 0;
          end
        end
      end
      if (ev) begin
        m_err = 1;
        m_ecnt = err_clr ? 1 : ((m_ecnt < 65535) ? m_ecnt + 1 : 65535);
      end else if (err_clr) begin
        m_err = 0;
        m_ecnt = 0;
      end
      m_en = 1;
    end
  end

  always @(negedge clk) begin
    check("in_rdy", in_rdy, m_ready());
    check("pt_empty", pt_empty, q[0].size() == 0);
    check("pt_aempty", pt_aempty, q[0].size() <= 1);
    check("pt_data", pt_data, (q[0].size() > 0) ? q[0][0] : '0);
    for (int k = 0; k < N_USR; k++) begin
      check($sformatf("usr_empty%0d", k), usr_empty[k], q[k+1].size() == 0);
      check($sformatf("usr_aempty%0d", k), usr_aempty[k], q[k+1].size() <= 1);
      check($sformatf("usr_data%0d", k), usr_data[k*E_W +: E_W],
            (q[k+1].size() > 0) ? q[k+1][0] : '0);
    end
    check("tlvp_error", tlvp_error, m_err);
    check("err_cnt", err_cnt, m_ecnt);
    check("drop_cnt", drop_cnt, m_dcnt);
  end

  // ---------------- stimulus ----------------
  function automatic logic [DATA_W-1:0] w(int tag, int t);
    return {16'hC0DE, 16'(tag), 27'd0, 5'(t)};
  endfunction

  task automatic send(bit s, bit e, logic [DATA_W-1:0] d);
    bit a;
    int n;
    in_vld = 1; in_sot = s; in_eot = e; in_data = d;
    n = 0;
    do begin
      @(negedge clk);
      a = in_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!a && n < 200);
    check("send_accept", a, 1'b1);
  endtask

  task automatic idle();
    in_vld = 0; in_sot = 0; in_eot = 0;
  endtask

  task automatic pop_chk(string n, int ch, logic [E_W-1:0] exp);
    @(negedge clk);
    if (ch < 0) begin
      check(n, pt_data, exp);
      pt_rd = 1;
    end else begin
      check(n, usr_data[ch*E_W +: E_W], exp);
      usr_rd[ch] = 1;
    end
    @(posedge clk);
    #1;
    pt_rd = 0;
    usr_rd = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    route_tbl[3*A_W +: A_W] = 3'b111;  // BOTH ch1
    route_tbl[1*A_W +: A_W] = 3'b010;  // PT
    route_tbl[2*A_W +: A_W] = 3'b100;  // USR ch0
    route_tbl[4*A_W +: A_W] = 3'b101;  // USR ch1
    #1 rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_pt_empty", pt_empty, 1'b1);
    check("rst_usr_empty", usr_empty, 2'b11);
    check("rst_err_cnt", err_cnt, 16'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rdy_before_edge", in_rdy, 1'b0);
    @(negedge clk);
    check("rdy_after_edge", in_rdy, 1'b1);
    @(posedge clk); #1;

    // BOTH-routed 3-word TLV lands identically in PT and USR1
    send(1, 0, w(1, 3)); send(0, 0, w(2, 3)); send(0, 1, w(3, 3)); idle();
    pop_chk("t43_pt0", -1, {3'b010, w(1, 3)});
    pop_chk("t43_pt1", -1, {3'b000, w(2, 3)});
    pop_chk("t43_pt2", -1, {3'b001, w(3, 3)});
    pop_chk("t43_u0", 1, {3'b010, w(1, 3)});
    pop_chk("t43_u1", 1, {3'b000, w(2, 3)});
    pop_chk("t43_u2", 1, {3'b001, w(3, 3)});
    @(negedge clk);
    check("t43_pt_empty", pt_empty, 1'b1);

    // USR0 full back-pressure, one pop frees a slot
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) send(1, 1, w(100 + i, 2));
    in_vld = 1; in_sot = 1; in_eot = 1; in_data = w(200, 2);
    @(negedge clk);
    check("t44_full_rdy", in_rdy, 1'b0);
    usr_rd = 2'b01;
    @(posedge clk); #1 usr_rd = '0;
    @(negedge clk);
    check("t44_rdy_after_pop", in_rdy, 1'b1);
    @(posedge clk); #1 idle();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (i == 0) check("t44_head_first", usr_data[E_W-1:0], {3'b011, w(101, 2)});
      if (i == DEPTH - 1) check("t44_head_last", usr_data[E_W-1:0], {3'b011, w(200, 2)});
      usr_rd = 2'b01;
      @(posedge clk); #1 usr_rd = '0;
    end

    // Nested SOT closes the TLV as errored, rest drained
    send(1, 0, w(1, 1)); send(0, 0, w(2, 1)); send(1, 0, w(3, 1));
    send(0, 0, w(4, 1)); send(0, 1, w(5, 1)); idle();
    @(negedge clk);
    check("t45_error", tlvp_error, 1'b1);
    check("t45_err_cnt", err_cnt, 16'd1);
    pop_chk("t45_pt0", -1, {3'b010, w(1, 1)});
    pop_chk("t45_pt1", -1, {3'b000, w(2, 1)});
    pop_chk("t45_pt2", -1, {3'b111, w(3, 1)});
    @(negedge clk);
    check("t45_pt_empty", pt_empty, 1'b1);

    // Orphan body words in IDLE are discarded, next TLV routes normally
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    @(negedge clk);
    check("t46_clr_cnt", err_cnt, 16'd0);
    check("t46_clr_flag", tlvp_error, 1'b0);
    @(posedge clk); #1;
    send(0, 0, w(1, 1)); send(0, 1, w(2, 1)); send(1, 0, w(3, 4)); send(0, 1, w(4, 4)); idle();
    @(negedge clk);
    check("t46_err_cnt", err_cnt, 16'd1);
    check("t46_pt_empty", pt_empty, 1'b1);
    pop_chk("t46_u0", 1, {3'b010, w(3, 4)});
    pop_chk("t46_u1", 1, {3'b001, w(4, 4)});

    // Reset mid-TLV discards everything
    send(1, 0, w(1, 3));
    for (int i = 2; i <= 5; i++) send(0, 0, w(i, 3));
    idle();
    @(negedge clk);
    check("t48_pt_filled", pt_empty, 1'b0);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    check("t48_pt_empty", pt_empty, 1'b1);
    check("t48_usr_empty", usr_empty, 2'b11);
    check("t48_rdy", in_rdy, 1'b0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send(1, 1, w(9, 2)); idle();
    pop_chk("t48_fresh", 0, {3'b011, w(9, 2)});

    // drop_cnt saturation, then err_clr colliding with an error
    for (int i = 0; i < 70000; i++) send(1, 1, w(i, 5));
    idle();
    @(negedge clk);
    check("t47_drop_sat", drop_cnt, 16'hFFFF);
    @(posedge clk); #1;
    send(0, 1, w(1, 1)); send(0, 1, w(2, 1)); idle();
    @(negedge clk);
    check("t47_err_two", err_cnt, 16'd2);
    @(posedge clk); #1 err_clr = 1;
    send(0, 1, w(3, 1));
    err_clr = 0; idle();
    @(negedge clk);
    check("t47_clr_err_cnt", err_cnt, 16'd1);
    check("t47_clr_err_flag", tlvp_error, 1'b1);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
